// File: rtl/uart_ram_loader.sv
`timescale 1ns/1ps
// Purpose: serial boot loader; 8N1 UART bytes -> framed 16-bit words -> RAM write port.
// Latency: ram_we / frame_ok / frame_err are registered, one cycle after the byte that triggers them.
// Backpressure: none; the UART cannot be stalled, so every received byte is consumed the cycle it lands.
// Ports: clk, rst (sync, active high), uart_rx (async, idle high);
//        ram_addr/ram_din/ram_we (write port, held between pulses);
//        busy (frame open), frame_ok / frame_err (one-cycle frame status pulses).
module uart_ram_loader #(
  parameter int DW      = 16,
  parameter int AW      = 13,
  parameter int CLK_DIV = 434,
  parameter int TO_CYC  = 100000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          uart_rx,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  output logic          busy,
  output logic          frame_ok,
  output logic          frame_err
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int TW = $clog2(TO_CYC + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);
  localparam logic [TW-1:0] TO_LOAD  = TW'(TO_CYC - 1);

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_REARM} rx_state_t;

  rx_state_t     rx_state, rx_next;
  logic          rx_m, rx_s, rx_d;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_byte;
  logic          byte_valid, byte_err;
  logic          bit_tick, half_tick;

  assign bit_tick  = (rx_cnt == BIT_END);
  assign half_tick = (rx_cnt == HALF_END);

  // Two synchronizer flops plus one delay flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= uart_rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (rx_d && !rx_s) rx_next = RX_START;
      // Line back high at mid start bit means it was a glitch.
      RX_START: if (half_tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_tick && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (bit_tick) rx_next = rx_s ? RX_IDLE : RX_REARM;
      // After a bad stop bit, wait for idle-high before looking for a new start.
      RX_REARM: if (rx_s) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      bit_idx    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      rx_state   <= rx_next;
      byte_valid <= (rx_state == RX_STOP) && bit_tick && rx_s;
      byte_err   <= (rx_state == RX_STOP) && bit_tick && !rx_s;
      if (rx_state == RX_IDLE || rx_state == RX_REARM ||
          (rx_state == RX_START && half_tick) || bit_tick)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + CW'(1);
      if (rx_state == RX_START) begin
        bit_idx <= '0;
      end else if (rx_state == RX_DATA && bit_tick) begin
        rx_byte <= {rx_s, rx_byte[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // ---------------- frame parser ----------------
  typedef enum logic [2:0] {F_SYNC, F_ADDR_H, F_ADDR_L, F_COUNT, F_DATA_H, F_DATA_L, F_CSUM} fr_state_t;

  fr_state_t     fr_state, fr_next;
  logic [7:0]    addr_h, data_h, words, csum;
  logic [AW-1:0] cur_addr;
  logic [TW-1:0] to_cnt;
  logic          wr_now, ok_now, err_now, timeout;

  assign busy = (fr_state != F_SYNC);
  // to_cnt is loaded with TO_CYC-1 the cycle after a byte; reaching 1 here
  // makes the registered error land exactly TO_CYC cycles after that byte.
  assign timeout = busy && !byte_valid && (to_cnt == TW'(1));

  always_comb begin
    fr_next = fr_state;
    wr_now  = 1'b0;
    ok_now  = 1'b0;
    err_now = 1'b0;
    if (busy && (byte_err || timeout)) begin
      err_now = 1'b0 | 1'b1;
      fr_next = F_SYNC;
    end else if (byte_valid) begin
      unique case (fr_state)
        F_SYNC:   if (rx_byte == 8'hA5) fr_next = F_ADDR_H;
        F_ADDR_H: fr_next = F_ADDR_L;
        F_ADDR_L: fr_next = F_COUNT;
        F_COUNT: begin
          if (rx_byte == 8'd0) begin
            err_now = 1'b1;
            fr_next = F_SYNC;
          end else begin
            fr_next = F_DATA_H;
          end
        end
        F_DATA_H: fr_next = F_DATA_L;
        F_DATA_L: begin
          wr_now  = 1'b1;
          fr_next = (words == 8'd1) ? F_CSUM : F_DATA_H;
        end
        F_CSUM: begin
          ok_now  = (rx_byte == csum);
          err_now = (rx_byte != csum);
          fr_next = F_SYNC;
        end
        default: fr_next = F_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fr_state  <= F_SYNC;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_we    <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      addr_h    <= '0;
      data_h    <= '0;
      words     <= '0;
      csum      <= '0;
      cur_addr  <= '0;
      to_cnt    <= '0;
    end else begin
      fr_state  <= fr_next;
      ram_we    <= wr_now;
      frame_ok  <= ok_now;
      frame_err <= err_now;
      if (byte_valid)
        to_cnt <= TO_LOAD;
      else if (to_cnt != '0)
        to_cnt <= to_cnt - TW'(1);
      if (wr_now) begin
        ram_addr <= cur_addr;
        ram_din  <= {data_h, rx_byte};
        cur_addr <= cur_addr + AW'(1);
      end
      if (byte_valid) begin
        unique case (fr_state)
          F_SYNC:   csum <= '0;
          F_ADDR_H: begin addr_h <= rx_byte; csum <= csum ^ rx_byte; end
          F_ADDR_L: begin cur_addr <= AW'({addr_h, rx_byte}); csum <= csum ^ rx_byte; end
          F_COUNT:  begin words <= rx_byte; csum <= csum ^ rx_byte; end
          F_DATA_H: begin data_h <= rx_byte; csum <= csum ^ rx_byte; end
          F_DATA_L: begin words <= words - 8'd1; csum <= csum ^ rx_byte; end
          default:  csum <= csum;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_ram_loader.sv
`timescale 1ns/1ps
module tb_uart_ram_loader;
  localparam int DW = 16, AW = 13, CLK_DIV = 16, TO_CYC = 200;
  localparam int EV_WR = 0, EV_OK = 1, EV_ERR = 2;

  typedef struct {
    int            kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
  } ev_t;

  logic          clk = 1'b0, rst = 1'b1, uart_rx = 1'b1;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we, busy, frame_ok, frame_err;

  int checks = 0, failures = 0, cyc = 0;
  ev_t exp_q[$];
  logic [15:0] wq[$];

  uart_ram_loader #(.DW(DW), .AW(AW), .CLK_DIV(CLK_DIV), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .busy(busy), .frame_ok(frame_ok), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_ev(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.dat = d;
    exp_q.push_back(e);
  endtask

  task automatic got(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event kind=%0d addr=%h din=%h required=no event", k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k == EV_WR && (e.addr != a || e.dat != d))) begin
        failures++;
        $display("FAIL event_order actual kind=%0d addr=%h din=%h required kind=%0d addr=%h din=%h",
                 k, a, d, e.kind, e.addr, e.dat);
      end
    end
  endtask

  // Scoreboard monitor: pops the expected event for every output strobe.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_ok || frame_err) begin
        checks++;
        if (frame_ok && frame_err) begin
          failures++;
          $display("FAIL ok_err_together actual ok=%b err=%b required=at most one", frame_ok, frame_err);
        end
      end
      if (ram_we)    got(EV_WR, ram_addr, ram_din);
      if (frame_ok)  got(EV_OK, '0, '0);
      if (frame_err) got(EV_ERR, '0, '0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop, output int t0);
    @(negedge clk);
    uart_rx = 1'b0;
    t0 = cyc;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    uart_rx = ~bad_stop;
    repeat (CLK_DIV) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic sb(input logic [7:0] b);
    int t;
    repeat ($urandom_range(0, 8)) @(negedge clk);
    send_byte(b, 1'b0, t);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk({name, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_we"}, ram_we, 0);
    chk({name, "_ok"}, frame_ok, 0);
    chk({name, "_err"}, frame_err, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_addr"}, ram_addr, 0);
    chk({name, "_din"}, ram_din, 0);
  endtask

  // Reference model: a frame is a list of words at consecutive addresses
  // (modulo 2^AW), followed by ok or err depending on the checksum.
  task automatic do_frame(input logic [15:0] a, input bit bad, input string name);
    logic [7:0]    cs;
    logic [AW-1:0] wa;
    cs = a[15:8] ^ a[7:0] ^ 8'(wq.size());
    wa = a[AW-1:0];
    foreach (wq[i]) begin
      expect_ev(EV_WR, wa, wq[i]);
      wa = wa + 1'b1;
      cs = cs ^ wq[i][15:8] ^ wq[i][7:0];
    end
    expect_ev(bad ? EV_ERR : EV_OK, '0, '0);
    sb(8'hA5); sb(a[15:8]); sb(a[7:0]); sb(8'(wq.size()));
    foreach (wq[i]) begin
      sb(wq[i][15:8]);
      sb(wq[i][7:0]);
    end
    sb(bad ? cs + 8'd1 : cs);
    wait_drain(name);
    chk({name, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int t0, te, n;
    logic [7:0] nb;
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("reset");

    wq = {16'h1234, 16'hABCD};
    do_frame(16'h0020, 1'b0, "basic");
    do_frame(16'h0020, 1'b1, "bad_csum");
    wq = {16'h0001, 16'h0002};
    do_frame(16'h1FFF, 1'b0, "wrap");

    // Noise bytes and a short glitch in SYNC: no activity expected.
    sb(8'h00);
    sb(8'hFF);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("noise_busy", busy, 0);
    expect_ev(EV_ERR, '0, '0);
    sb(8'hA5); sb(8'h00); sb(8'h20); sb(8'h00); sb(8'h20);
    wait_drain("count0");
    chk("count0_busy", busy, 0);

    // Bad stop bit on DATA_L of the first word.
    expect_ev(EV_ERR, '0, '0);
    sb(8'hA5); sb(8'h01); sb(8'h00); sb(8'h02); sb(8'h55);
    send_byte(8'h66, 1'b1, t0);
    repeat (20) @(negedge clk);
    wait_drain("framing");
    chk("framing_busy", busy, 0);
    wq = {16'hCAFE, 16'h0F0F};
    do_frame(16'h0100, 1'b0, "after_framing");

    // Inter-byte timeout after ADDR_L.
    expect_ev(EV_ERR, '0, '0);
    sb(8'hA5);
    chk("timeout_busy_open", busy, 1);
    sb(8'h03);
    send_byte(8'h40, 1'b0, t0);
    te = -1;
    for (int i = 0; i < 600 && te < 0; i++) begin
      @(negedge clk);
      if (frame_err) te = cyc;
    end
    // byte_valid lands 155 cycles after the start bit is driven (sync + mid-bit sampling).
    chk("timeout_cycle", te, t0 + 155 + TO_CYC);
    wait_drain("timeout");
    chk("timeout_busy", busy, 0);

    // Reset in the middle of the data section.
    expect_ev(EV_WR, 13'h0300, 16'hBEEF);
    sb(8'hA5); sb(8'h03); sb(8'h00); sb(8'h02); sb(8'hBE); sb(8'hEF); sb(8'h12);
    wait_drain("pre_rst");
    chk("pre_rst_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("mid_rst");
    rst = 1'b0;
    repeat (TO_CYC + 100) @(negedge clk);
    chk("post_rst_quiet", exp_q.size(), 0);
    chk("post_rst_busy", busy, 0);

    // Randomized frames with optional leading noise.
    for (int f = 0; f < 10; f++) begin
      if ($urandom_range(0, 1) == 1) begin
        nb = 8'($urandom);
        if (nb == 8'hA5) nb = 8'h5A;
        sb(nb);
      end
      wq.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
      do_frame(16'($urandom), $urandom_range(0, 3) == 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (95000) @(posedge clk);
    failures++;
    $display("FAIL watchdog cycles=%0d required=finish earlier", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/uart_ram_loader.md
Name: uart_ram_loader

Overview:
- Serial boot/debug loader that sits directly upstream of the data RAM write port.
- Receives framed 8N1 UART bytes, assembles 16-bit words and writes them into RAM at consecutive addresses.
- Asserts busy so top level holds the core and muxes RAM din/addr/we to this block while loading.
- Addresses are not special-cased: a write to 0x101 reaches the GPIO output register like any core store.

Parameters:
- DW, 16, RAM data width; must be 16.
- AW, 13, RAM address width.
- CLK_DIV, 434, clock cycles per UART bit (e.g. 50 MHz / 115200); minimum 8.
- TO_CYC, 100000, inter-byte timeout in clock cycles while a frame is open.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- uart_rx  in  1  asynchronous serial input, idle high.
- ram_addr  out  AW  RAM write address.
- ram_din  out  DW  RAM write data.
- ram_we  out  1  RAM write enable, one-cycle pulse per word.
- busy  out  1  frame in progress; top level holds core and selects loader onto RAM.
- frame_ok  out  1  one-cycle pulse: frame complete, checksum matched.
- frame_err  out  1  one-cycle pulse: frame aborted or checksum mismatch.

Behaviour:
- Reset: all outputs 0; receiver and frame FSM return to idle/SYNC; checksum and counters cleared. Reset mid-frame abandons the frame with no err pulse. Words already written stay written.
- RX input: uart_rx passes through a 2-flop synchronizer, reset to 1.
- RX start detection: falling edge of the synced line starts a bit counter.
- RX start validation: at CLK_DIV/2 the line is resampled. If it is high, treat as a glitch and return to idle.
- RX data bits: 8 bits sampled every CLK_DIV cycles after the start-bit midpoint, LSB first.
- RX stop bit: sampled one bit period after the last data bit. If high, an internal byte_valid pulses for 1 cycle in the following cycle.
- RX framing error: stop bit low. Byte is discarded; if a frame is open, frame_err pulses and the FSM returns to SYNC. The receiver re-arms only after the line is seen high.
- Frame format, one byte each, in order:
  - SYNC = 0xA5
  - ADDR_H, ADDR_L (address = {ADDR_H, ADDR_L} truncated to AW bits)
  - COUNT (words, 1..255)
  - COUNT pairs of DATA_H, DATA_L
  - CSUM
- FSM states: SYNC, ADDR_H, ADDR_L, COUNT, DATA_H, DATA_L, CSUM. Each byte_valid advances one state.
- SYNC state: non-0xA5 bytes are ignored silently.
- Busy: rises the cycle after the SYNC byte is accepted; falls in the same cycle frame_ok/frame_err pulses.
- COUNT = 0: frame_err, return to SYNC.
- Word write: on byte_valid of DATA_L, in the next cycle ram_we=1 for exactly 1 cycle, ram_din={DATA_H, DATA_L}, ram_addr=current address.
- Address advance: after each write the address increments modulo 2^AW (0x1FFF wraps to 0x0000). Word counter decrements; at 0 go to CSUM, else DATA_H.
- Held outputs: ram_addr/ram_din hold their last values when ram_we=0.
- Checksum: XOR of ADDR_H, ADDR_L, COUNT and all data bytes.
  - CSUM byte equal: frame_ok pulses 1 cycle after its byte_valid.
  - CSUM byte unequal: frame_err pulses instead. Data is already written and is not rolled back.
- Timeout: while busy, a counter reloads on every byte_valid. If TO_CYC cycles elapse with no byte_valid, frame_err pulses and the FSM returns to SYNC.
- Mutual exclusion: frame_ok and frame_err never assert together; at most one pulse per frame.
- Back-to-back frames: a new SYNC may follow CSUM immediately; no gap is required.

Test Plan:
- CLK_DIV=16. Send A5 00 20 02 12 34 AB CD, CSUM=0x20^0x02^0x12^0x34^0xAB^0xCD → two ram_we pulses, (0x0020,0x1234) then (0x0021,0xABCD); frame_ok=1 once; busy low after.
- Same frame with CSUM off by one → both words written, frame_err=1, frame_ok stays 0.
- ADDR=0x1FFF, COUNT=2, data 0001 0002 → writes at 0x1FFF then 0x0000.
- Send 00 FF A5 with a 3-cycle low glitch before the A5 → glitch ignored, no activity until A5. Then send the frame with COUNT=0 → frame_err, no ram_we.
- Stop bit forced low on the second data byte → frame_err, no write for that word, busy drops; following valid frame succeeds.
- TO_CYC=200: stop after ADDR_L → frame_err exactly 200 cycles after last byte_valid. Separately, assert rst mid-DATA → all outputs 0 next cycle, no pulses.
